xor_autotest: RTL and testbench
===============================

XOR_AUTOTEST -- requirements
Module: xor_autotest

Interface
REQ-001 SHALL provide parameter SETTLE, default 1, meaning cycles a vector is held on a_o/b_o before z_i is sampled; legal range 1..15.
REQ-002 SHALL provide parameter STOP_ON_FAIL, default 1, meaning 1 = end the run at the first mismatch, 0 = sweep all 256 vectors.
REQ-003 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  run request, sampled only in IDLE and DONE.
REQ-006 SHALL have port a_o  output  4  operand a driven to the XOR under test.
REQ-007 SHALL have port b_o  output  4  operand b driven to the XOR under test.
REQ-008 SHALL have port z_i  input  4  result returned by the XOR under test.
REQ-009 SHALL have port busy  output  1  high while in SETTLE or CHECK.
REQ-010 SHALL have port done  output  1  high while in DONE.
REQ-011 SHALL have port pass  output  1  high in DONE when no mismatch occurred in the run.
REQ-012 SHALL have port err_a  output  4  a_o of the first mismatching vector.
REQ-013 SHALL have port err_b  output  4  b_o of the first mismatching vector.
REQ-014 SHALL have port err_z  output  4  z_i sampled at the first mismatch.
REQ-015 SHALL have port err_count  output  9  number of mismatching vectors in the run, 0..256.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, CHECK, DONE.
REQ-017 IDLE/DONE with start=1 SHALL: clear pass, err_a/b/z, err_count, set a_o=0, b_o=0, load settle counter with SETTLE, and go to SETTLE on the next edge.
REQ-018 SETTLE SHALL decrement the settle counter each cycle and go to CHECK after exactly SETTLE cycles.
REQ-019 CHECK SHALL compare z_i against a_o^b_o in a single cycle.
REQ-020 Mismatch in CHECK SHALL increment err_count; the first mismatch of a run SHALL also capture err_a/err_b/err_z, with later mismatches leaving them unchanged.
REQ-021 Vector order SHALL be b_o inner and a_o outer: index = {a_o,b_o}, incrementing 0..255.
REQ-022 From CHECK SHALL go to DONE when index = 255, or on a mismatch with STOP_ON_FAIL=1; otherwise SHALL increment index, reload the settle counter, and return to SETTLE.
REQ-023 Each vector SHALL occupy SETTLE+1 cycles; a full clean run SHALL raise done 1+256*(SETTLE+1) cycles after the start-sampling edge.
REQ-024 Entering DONE SHALL set pass=1 iff err_count=0; DONE SHALL hold all outputs until start or rst.
REQ-025 start while busy SHALL be ignored, with no restart and no effect on counters.
REQ-026 a_o/b_o SHALL remain stable throughout SETTLE and CHECK of a vector, changing only on the edge leaving CHECK.
REQ-027 Index wrap 255->0 SHALL never occur within a run.
REQ-028 err_count SHALL reach at most 256 and not overflow.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, with a_o=0, b_o=0, busy=0, done=0, pass=0, err_a/b/z=0, err_count=0.
REQ-030 rst mid-run SHALL abort the run with no done pulse; the next start SHALL begin at vector 0.
REQ-031 rst SHALL take priority over start on the same edge.

Verification
REQ-032 Correct XOR model, SETTLE=1 -> done at cycle 513 after start, pass=1, err_count=0.
REQ-033 z_i=(a^b)|4'h1, STOP_ON_FAIL=1 -> done after first vector, pass=0, err_a=0, err_b=0, err_z=1, err_count=1.
REQ-034 Same fault, STOP_ON_FAIL=0 -> full 256-vector sweep, err_count=128, err_a=0, err_b=0, err_z=1, pass=0.
REQ-035 SETTLE=3, correct model -> done at cycle 1025; a_o/b_o constant for 4 cycles per vector.
REQ-036 rst asserted at cycle 100 of a run, then start -> all outputs zero after rst; restarted run begins at a_o=0, b_o=0 and ends pass=1.
REQ-037 start pulsed during busy, then again in DONE -> first pulse ignored; second pulse clears results and reruns.

Source files
------------

// File: rtl/xor_autotest.sv
// xor_autotest: built-in self test for an external 4-bit XOR.
// Walks all 256 {a,b} operand pairs, holds each pair for SETTLE cycles,
// then compares the returned result against a^b. It counts mismatches
// and keeps the operands and result of the first failing vector.
module xor_autotest #(
    parameter int unsigned SETTLE       = 1,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] a_o,
    output logic [3:0] b_o,
    input  logic [3:0] z_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_a,
    output logic [3:0] err_b,
    output logic [3:0] err_z,
    output logic [8:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

    state_t     state;
    logic [7:0] vec_idx;
    logic [3:0] settle_cnt;
    logic       mismatch;
    logic [8:0] next_count;

    // The vector index is the operand pair itself: a is the outer loop, b the inner.
    assign a_o = vec_idx[7:4];
    assign b_o = vec_idx[3:0];

    // Compare the returned result against the golden XOR and form the updated error tally.
    always_comb begin
        mismatch   = 1'b0;
        next_count = err_count;
        if (state == ST_CHECK && z_i != (a_o ^ b_o)) begin
            mismatch   = 1'b1;
            next_count = err_count + 9'd1;
        end
    end

    // Sequencer: launch on start, settle each vector, check it, then advance or finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            vec_idx    <= 8'd0;
            settle_cnt <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_a      <= 4'd0;
            err_b      <= 4'd0;
            err_z      <= 4'd0;
            err_count  <= 9'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec_idx    <= 8'd0;
                        settle_cnt <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_a      <= 4'd0;
                        err_b      <= 4'd0;
                        err_z      <= 4'd0;
                        err_count  <= 9'd0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_count <= next_count;
                    if (mismatch && err_count == 9'd0) begin
                        err_a <= a_o;
                        err_b <= b_o;
                        err_z <= z_i;
                    end
                    if (vec_idx == 8'hFF || (mismatch && STOP_ON_FAIL)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (next_count == 9'd0);
                        state <= ST_DONE;
                    end else begin
                        vec_idx    <= vec_idx + 8'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_SETTLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_autotest.sv
// tb_xor_autotest: drives three xor_autotest instances (SETTLE=1 stop-on-fail,
// SETTLE=1 full sweep, SETTLE=3 stop-on-fail) against a behavioural XOR that
// can be switched to a stuck-at-1 fault on bit 0.
module tb_xor_autotest;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    bit         fault = 1'b0;
    logic       start [3];
    logic [3:0] a_o [3];
    logic [3:0] b_o [3];
    logic [3:0] z_i [3];
    logic       busy [3];
    logic       done [3];
    logic       pass [3];
    logic [3:0] err_a [3];
    logic [3:0] err_b [3];
    logic [3:0] err_z [3];
    logic [8:0] err_count [3];

    int checks = 0;
    int errors = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [3:0] xor_ref(input logic [3:0] a, input logic [3:0] b, input bit f);
        return f ? ((a ^ b) | 4'h1) : (a ^ b);
    endfunction

    assign z_i[0] = xor_ref(a_o[0], b_o[0], fault);
    assign z_i[1] = xor_ref(a_o[1], b_o[1], fault);
    assign z_i[2] = xor_ref(a_o[2], b_o[2], fault);

    xor_autotest #(.SETTLE(1), .STOP_ON_FAIL(1'b1)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .a_o(a_o[0]), .b_o(b_o[0]), .z_i(z_i[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_a(err_a[0]), .err_b(err_b[0]),
        .err_z(err_z[0]), .err_count(err_count[0]));

    xor_autotest #(.SETTLE(1), .STOP_ON_FAIL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .a_o(a_o[1]), .b_o(b_o[1]), .z_i(z_i[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_a(err_a[1]), .err_b(err_b[1]),
        .err_z(err_z[1]), .err_count(err_count[1]));

    xor_autotest #(.SETTLE(3), .STOP_ON_FAIL(1'b1)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .a_o(a_o[2]), .b_o(b_o[2]), .z_i(z_i[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_a(err_a[2]), .err_b(err_b[2]),
        .err_z(err_z[2]), .err_count(err_count[2]));

    typedef struct {
        string      name;
        int         dut;
        bit         flt;
        int         exp_cycle;
        bit         exp_pass;
        logic [3:0] exp_ea;
        logic [3:0] exp_eb;
        logic [3:0] exp_ez;
        logic [8:0] exp_cnt;
        logic [7:0] exp_last;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] packAll(input int k);
        return {9'd0, a_o[k], b_o[k], busy[k], done[k], pass[k], err_a[k], err_b[k], err_z[k], err_count[k]};
    endfunction

    // Pulse start across one rising edge; returns #1 after that sampling edge.
    task automatic applyStimulus(input int k);
        @(negedge clk);
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
    endtask

    // Count edges until done is seen, bounded by budget.
    task automatic waitDone(input int k, input int budget, output int edges);
        edges = 0;
        while (done[k] !== 1'b1 && edges < budget) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        int   edges;
        int   bad;
        int   len;
        bit   saw_done;
        logic [7:0] prev;
        logic [7:0] cur;

        for (int k = 0; k < 3; k++) start[k] = 1'b0;

        // Cycle numbering: the cycle in which start is high is cycle 0,
        // so done seen after N edges past the sampling edge is cycle N+1.
        vecs[0] = '{"clean_s1", 0, 1'b0,  513, 1'b1, 4'h0, 4'h0, 4'h0, 9'd0,   8'hFF};
        vecs[1] = '{"stop_s1",  0, 1'b1,    3, 1'b0, 4'h0, 4'h0, 4'h1, 9'd1,   8'h00};
        vecs[2] = '{"sweep_s1", 1, 1'b1,  513, 1'b0, 4'h0, 4'h0, 4'h1, 9'd128, 8'hFF};
        vecs[3] = '{"clean_s3", 2, 1'b0, 1025, 1'b1, 4'h0, 4'h0, 4'h0, 9'd0,   8'hFF};
        vecs[4] = '{"stop_s3",  2, 1'b1,    5, 1'b0, 4'h0, 4'h0, 4'h1, 9'd1,   8'h00};
        vecs[5] = '{"clean_sw", 1, 1'b0,  513, 1'b1, 4'h0, 4'h0, 4'h0, 9'd0,   8'hFF};

        doReset();
        for (int k = 0; k < 3; k++) checkOutput($sformatf("reset_state_%0d", k), packAll(k), 32'd0);

        for (int i = 0; i < 6; i++) begin
            int k;
            k = vecs[i].dut;
            fault = vecs[i].flt;
            doReset();
            applyStimulus(k);
            checkOutput({vecs[i].name, "_busy"}, {31'd0, busy[k]}, 32'd1);
            waitDone(k, vecs[i].exp_cycle + 20, edges);
            checkOutput({vecs[i].name, "_cycle"}, edges + 1, vecs[i].exp_cycle);
            checkOutput({vecs[i].name, "_pass"}, {31'd0, pass[k]}, {31'd0, vecs[i].exp_pass});
            checkOutput({vecs[i].name, "_err"}, {20'd0, err_a[k], err_b[k], err_z[k]},
                        {20'd0, vecs[i].exp_ea, vecs[i].exp_eb, vecs[i].exp_ez});
            checkOutput({vecs[i].name, "_count"}, {23'd0, err_count[k]}, {23'd0, vecs[i].exp_cnt});
            checkOutput({vecs[i].name, "_last"}, {24'd0, a_o[k], b_o[k]}, {24'd0, vecs[i].exp_last});
            repeat (3) @(posedge clk);
            #1;
            checkOutput({vecs[i].name, "_hold"}, {22'd0, busy[k], done[k], err_count[k]},
                        {22'd0, 1'b0, 1'b1, vecs[i].exp_cnt});
        end

        // Reset at cycle 100 of a run aborts it; the next run starts at vector 0.
        fault = 1'b0;
        doReset();
        applyStimulus(0);
        saw_done = 1'b0;
        repeat (99) begin
            @(posedge clk);
            #1;
            if (done[0] === 1'b1) saw_done = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_outputs", packAll(0), 32'd0);
        checkOutput("midrst_no_done", {31'd0, saw_done}, 32'd0);
        rst = 1'b0;
        applyStimulus(0);
        checkOutput("midrst_restart_vec", {23'd0, busy[0], a_o[0], b_o[0]}, {23'd0, 1'b1, 8'h00});
        waitDone(0, 600, edges);
        checkOutput("midrst_cycle", edges + 1, 513);
        checkOutput("midrst_pass", {31'd0, pass[0]}, 32'd1);

        // Reset wins over start on the same edge (dut0 is sitting in DONE).
        @(negedge clk);
        rst = 1'b1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start[0] = 1'b0;
        checkOutput("rst_priority", packAll(0), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_priority_idle", {31'd0, busy[0]}, 32'd0);

        // Start while busy is ignored; start in DONE clears and reruns.
        fault = 1'b1;
        doReset();
        applyStimulus(1);
        repeat (50) @(posedge clk);
        applyStimulus(1);
        checkOutput("busy_start_busy", {31'd0, busy[1]}, 32'd1);
        waitDone(1, 600, edges);
        checkOutput("busy_start_cycle", edges + 51 + 1, 513);
        checkOutput("busy_start_count", {23'd0, err_count[1]}, 32'd128);
        fault = 1'b0;
        applyStimulus(1);
        checkOutput("rerun_cleared", {14'd0, busy[1], done[1], pass[1], err_count[1], a_o[1], b_o[1]},
                    {14'd0, 1'b1, 1'b0, 1'b0, 9'd0, 8'h00});
        waitDone(1, 600, edges);
        checkOutput("rerun_cycle", edges + 1, 513);
        checkOutput("rerun_result", {22'd0, pass[1], err_count[1]}, {22'd0, 1'b1, 9'd0});

        // SETTLE=3: every vector held exactly 4 cycles and stepping by one.
        doReset();
        applyStimulus(2);
        prev = {a_o[2], b_o[2]};
        len = 1;
        bad = 0;
        for (int n = 1; n < 1024; n++) begin
            @(posedge clk);
            #1;
            cur = {a_o[2], b_o[2]};
            if (cur != prev) begin
                if (len != 4) bad++;
                if (cur != prev + 8'd1) bad++;
                prev = cur;
                len = 1;
            end else begin
                len++;
            end
        end
        if (len != 4) bad++;
        checkOutput("s3_hold_violations", bad, 0);
        checkOutput("s3_last_vec", {24'd0, prev}, 32'hFF);
        checkOutput("s3_done_not_early", {31'd0, done[2]}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("s3_done_at_1025", {30'd0, done[2], pass[2]}, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
